// File: rtl/output_encoder.sv
// output_encoder: signed integer to decimal ASCII byte stream with optional separator.
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   in_value  signed value to print (DATA_W bits)
//   in_sep    separator: 0 none, 1 space, 2 LF, 3 CR LF
//   in_valid  producer offers in_value/in_sep
//   in_ready  encoder can accept (transfer on in_valid && in_ready)
//   tx_data   ASCII byte to uart_tx, stable while tx_valid && !tx_ready
//   tx_valid  tx_data valid
//   tx_ready  uart_tx accepts the byte
//   busy      high from accepted input until last byte accepted
//   done      one-cycle pulse after the last byte is accepted
// Build option: define ENCODER_PAD_EN to right-align numbers in FIELD_W columns with spaces.
module output_encoder #(
   parameter int DATA_W  = 32,
   parameter int MAX_DIG = 10,
   parameter int FIELD_W = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] in_value,
   input  logic [1:0]        in_sep,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              busy,
   output logic              done
);
   localparam int KW = $clog2(MAX_DIG);
`ifdef ENCODER_PAD_EN
   typedef enum logic [2:0] {IDLE, CONVERT, PAD, SIGN, DIGITS, SEP} state_t;
`else
   typedef enum logic [2:0] {IDLE, CONVERT, SIGN, DIGITS, SEP} state_t;
`endif
   function automatic logic [DATA_W-1:0] pow10(input int n);
      logic [DATA_W-1:0] p;
      p = DATA_W'(1);
      for (int j = 0; j < n; j++) p = p * DATA_W'(10);
      return p;
   endfunction
   logic [DATA_W-1:0] pow_tab [MAX_DIG];
   for (genvar i = 0; i < MAX_DIG; i++) begin : g_pow
      assign pow_tab[i] = pow10(i);
   end
   state_t                    state, state_n;
   logic                      sign, sign_n;
   logic [DATA_W-1:0]         mag, mag_n;
   logic [1:0]                sep, sep_n;
   logic [KW-1:0]             k, k_n;
   logic [MAX_DIG-1:0][3:0]   digs, digs_n;
   logic [KW-1:0]             top, top_n;
   logic                      found, found_n;
   logic [KW-1:0]             idx, idx_n;
   logic                      sep_lf, sep_lf_n;
   logic [7:0]                tx_data_n;
   logic                      tx_valid_n;
   logic                      done_n;
`ifdef ENCODER_PAD_EN
   logic [7:0]                pcnt, pcnt_n;
   logic [7:0]                nchar;
   logic                      pad_more;
   assign nchar    = 8'(sign) + 8'(top) + 8'd1;
   assign pad_more = (pcnt + nchar) < 8'(FIELD_W);
`endif
   assign in_ready = state == IDLE;
   assign busy     = state != IDLE;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         sign     <= 1'b0;
         mag      <= '0;
         sep      <= '0;
         k        <= '0;
         digs     <= '0;
         top      <= '0;
         found    <= 1'b0;
         idx      <= '0;
         sep_lf   <= 1'b0;
         tx_data  <= 8'h00;
         tx_valid <= 1'b0;
         done     <= 1'b0;
`ifdef ENCODER_PAD_EN
         pcnt     <= '0;
`endif
      end else begin
         state    <= state_n;
         sign     <= sign_n;
         mag      <= mag_n;
         sep      <= sep_n;
         k        <= k_n;
         digs     <= digs_n;
         top      <= top_n;
         found    <= found_n;
         idx      <= idx_n;
         sep_lf   <= sep_lf_n;
         tx_data  <= tx_data_n;
         tx_valid <= tx_valid_n;
         done     <= done_n;
`ifdef ENCODER_PAD_EN
         pcnt     <= pcnt_n;
`endif
      end
   end
   // Every emitting state uses the same two-step handshake: raise tx_valid with
   // the byte, then drop it and advance once the byte is accepted.
   always_comb begin
      state_n    = state;
      sign_n     = sign;
      mag_n      = mag;
      sep_n      = sep;
      k_n        = k;
      digs_n     = digs;
      top_n      = top;
      found_n    = found;
      idx_n      = idx;
      sep_lf_n   = sep_lf;
      tx_data_n  = tx_data;
      tx_valid_n = tx_valid;
      done_n     = 1'b0;
`ifdef ENCODER_PAD_EN
      pcnt_n     = pcnt;
`endif
      case (state)
         IDLE: begin
            if (in_valid) begin
               sign_n   = in_value[DATA_W-1];
               // Unsigned negate: the most negative value maps to 2^(DATA_W-1).
               mag_n    = in_value[DATA_W-1] ? ~in_value + 1'b1 : in_value;
               sep_n    = in_sep;
               k_n      = KW'(MAX_DIG - 1);
               digs_n   = '0;
               top_n    = '0;
               found_n  = 1'b0;
               sep_lf_n = 1'b0;
`ifdef ENCODER_PAD_EN
               pcnt_n   = '0;
`endif
               state_n  = CONVERT;
            end
         end
         CONVERT: begin
            if (mag >= pow_tab[k]) begin
               mag_n     = mag - pow_tab[k];
               digs_n[k] = digs[k] + 4'd1;
            end else begin
               // The first nonzero digit from the top fixes the printed length;
               // an all-zero value keeps top=0 and prints a single '0'.
               if (digs[k] != 4'd0 && !found) begin
                  top_n   = k;
                  found_n = 1'b1;
               end
               if (k == '0) begin
`ifdef ENCODER_PAD_EN
                  state_n = PAD;
`else
                  state_n = SIGN;
`endif
               end else begin
                  k_n = k - KW'(1);
               end
            end
         end
`ifdef ENCODER_PAD_EN
         PAD: begin
            if (!pad_more) begin
               state_n = SIGN;
            end else if (!tx_valid) begin
               tx_data_n  = 8'h20;
               tx_valid_n = 1'b1;
            end else if (tx_ready) begin
               tx_valid_n = 1'b0;
               pcnt_n     = pcnt + 8'd1;
            end
         end
`endif
         SIGN: begin
            if (!sign) begin
               state_n = DIGITS;
               idx_n   = top;
            end else if (!tx_valid) begin
               tx_data_n  = 8'h2D;
               tx_valid_n = 1'b1;
            end else if (tx_ready) begin
               tx_valid_n = 1'b0;
               state_n    = DIGITS;
               idx_n      = top;
            end
         end
         DIGITS: begin
            if (!tx_valid) begin
               tx_data_n  = 8'h30 + {4'h0, digs[idx]};
               tx_valid_n = 1'b1;
            end else if (tx_ready) begin
               tx_valid_n = 1'b0;
               if (idx != '0) begin
                  idx_n = idx - KW'(1);
               end else if (sep == 2'd0) begin
                  state_n = IDLE;
                  done_n  = 1'b1;
               end else begin
                  state_n = SEP;
               end
            end
         end
         SEP: begin
            if (!tx_valid) begin
               tx_data_n  = sep == 2'd1 ? 8'h20 : (sep == 2'd3 && !sep_lf) ? 8'h0D : 8'h0A;
               tx_valid_n = 1'b1;
            end else if (tx_ready) begin
               tx_valid_n = 1'b0;
               if (sep == 2'd3 && !sep_lf) begin
                  sep_lf_n = 1'b1;
               end else begin
                  state_n = IDLE;
                  done_n  = 1'b1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_output_encoder.sv
// tb_output_encoder: scoreboard bench for output_encoder with a decimal-printing reference model.
module tb_output_encoder;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] in_value = '0;
   logic [1:0]  in_sep = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic        busy;
   logic        done;
   int          checks = 0;
   int          errors = 0;
   int          rdy_mode = 0;
   logic [7:0]  exp_q [$];

   always #5 clk = ~clk;

   output_encoder dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_value (in_value),
      .in_sep   (in_sep),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .busy     (busy),
      .done     (done)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Reference: print the value in decimal using plain integer arithmetic.
   function automatic void model(input logic [31:0] v, input logic [1:0] s);
      longint     m;
      bit         neg;
      logic [7:0] d [$];
      m   = longint'($signed(v));
      neg = m < 0;
      if (neg) m = -m;
      do begin
         d.push_front(8'(48 + m % 10));
         m = m / 10;
      end while (m != 0);
`ifdef ENCODER_PAD_EN
      for (int i = d.size() + int'(neg); i < 6; i++) exp_q.push_back(8'h20);
`endif
      if (neg) exp_q.push_back(8'h2D);
      foreach (d[i]) exp_q.push_back(d[i]);
      if (s == 2'd1) exp_q.push_back(8'h20);
      if (s == 2'd2) exp_q.push_back(8'h0A);
      if (s == 2'd3) begin
         exp_q.push_back(8'h0D);
         exp_q.push_back(8'h0A);
      end
   endfunction

   // Consumer: always ready, random stalls, or five stall cycles before each byte.
   initial begin
      int cnt;
      cnt = 0;
      forever begin
         @(posedge clk);
         #1;
         if (rdy_mode == 0) tx_ready = 1'b1;
         else if (rdy_mode == 1) tx_ready = $urandom_range(0, 3) != 0;
         else if (!tx_valid) begin
            cnt = 0;
            tx_ready = 1'b0;
         end else if (cnt < 5) begin
            cnt++;
            tx_ready = 1'b0;
         end else tx_ready = 1'b1;
      end
   end

   // Monitor: pops one expected byte per accepted transfer, checks hold and done timing.
   initial begin
      logic       pend;
      logic [7:0] pd;
      logic       due;
      pend = 1'b0;
      pd   = '0;
      due  = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pend = 1'b0;
            due  = 1'b0;
         end else begin
            if (pend) chk("hold", {tx_valid, tx_data}, {1'b1, pd});
            if (due || done) chk("done_timing", done, due);
            due = 1'b0;
            if (tx_valid && tx_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL extra_byte actual=%0h expected=none", tx_data);
               end else chk("byte", tx_data, exp_q.pop_front());
               due = exp_q.size() == 0;
            end
            pend = tx_valid && !tx_ready;
            pd   = tx_data;
         end
      end
   end

   task automatic issue(input logic [31:0] v, input logic [1:0] s);
      int n;
      n = 0;
      while (!in_ready && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("in_ready_wait", in_ready, 1);
      model(v, s);
      in_value = v;
      in_sep   = s;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_value = $urandom;
      in_sep   = 2'($urandom);
      chk("busy_after_accept", {busy, in_ready}, 2'b10);
   endtask

   task automatic finish(input bit hold);
      int n;
      n = 0;
      if (hold) begin
         in_valid = 1'b1;
         in_value = 32'd999;
      end
      while (!done && n < 3000) begin
         if (hold) chk("ignored_while_busy", in_ready, 0);
         @(posedge clk);
         #1;
         n++;
      end
      in_valid = 1'b0;
      chk("done_seen", done, 1);
      chk("idle_at_done", {busy, in_ready}, 2'b01);
      @(posedge clk);
      #1;
      chk("done_one_cycle", done, 0);
   endtask

   task automatic send(input logic [31:0] v, input logic [1:0] s);
      issue(v, s);
      finish(1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] v;
      int n;
      #12;
      chk("reset_outputs", {tx_data, tx_valid, busy, done}, 11'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("ready_after_reset", in_ready, 1);
      rdy_mode = 0;
      send(32'd0, 2'd1);
      send(-32'sd123, 2'd3);
      send(32'h80000000, 2'd0);
      send(32'd2147483647, 2'd0);
      rdy_mode = 2;
      issue(32'd405, 2'd0);
      finish(1'b1);
      rdy_mode = 0;
      issue(32'd98765, 2'd1);
      n = 0;
      while (!(tx_valid && tx_data == 8'h38) && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("second_digit_reached", {tx_valid, tx_data}, {1'b1, 8'h38});
      rst_n = 1'b0;
      #1;
      chk("abort_outputs", {tx_data, tx_valid, busy, done}, 11'h0);
      exp_q.delete();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("ready_after_abort", in_ready, 1);
      send(32'd7, 2'd2);
      rdy_mode = 1;
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 4))
            0: v = $urandom;
            1: v = $urandom_range(0, 20);
            2: v = -$urandom_range(0, 20);
            3: v = $urandom_range(0, 1) != 0 ? 32'h80000000 : 32'h7fffffff;
            default: v = $urandom_range(0, 1) != 0 ? $urandom_range(0, 999999) : -$urandom_range(0, 999999);
         endcase
         send(v, 2'($urandom));
      end
      chk("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
